// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU-op classes and the ID/EX control bundle.
package pipeline_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned FUNCT_W   = 4;
  localparam int unsigned ALU_OP_W  = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // A bubble is an instruction with every side effect disabled.
  localparam ctrl_t CTRL_BUBBLE = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    branch:     1'b0,
    alu_op:     ALU_ADD
  };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hazard
);

  logic rd_nonzero;
  logic src_match;

  // Both sources are compared even if the ID instruction does not read rs2.
  assign rd_nonzero = (ex_rd != REG_IDX_W'(0));
  assign src_match  = (ex_rd == id_rs1) | (ex_rd == id_rs2);
  assign hazard     = ex_valid & ex_mem_read & rd_nonzero & id_valid & src_match;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and a saturating stall counter.
module id_ex_hazard_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [3:0]       id_funct,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_alu_src,
  input  logic             id_branch,
  input  logic [1:0]       id_alu_op,
  input  logic             branch_taken_flush,
  output logic             ID_EX_Valid,
  output logic [XLEN-1:0]  ID_EX_PC,
  output logic [XLEN-1:0]  ID_EX_RS1_Data,
  output logic [XLEN-1:0]  ID_EX_RS2_Data,
  output logic [XLEN-1:0]  ID_EX_Imm,
  output logic [4:0]       ID_EX_RS1,
  output logic [4:0]       ID_EX_RS2,
  output logic [4:0]       ID_EX_RD,
  output logic [3:0]       ID_EX_Funct,
  output logic             ID_EX_RegWrite,
  output logic             ID_EX_MemRead,
  output logic             ID_EX_MemWrite,
  output logic             ID_EX_MemToReg,
  output logic             ID_EX_ALUSrc,
  output logic             ID_EX_Branch,
  output logic [1:0]       ID_EX_ALUOp,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic [CNT_W-1:0] stall_count
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  hazard;
  logic  stall;
  logic  cnt_at_max;

  assign id_ctrl = '{
    reg_write:  id_reg_write,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    mem_to_reg: id_mem_to_reg,
    alu_src:    id_alu_src,
    branch:     id_branch,
    alu_op:     alu_op_e'(id_alu_op)
  };

  load_use_detect u_load_use_detect (
    .ex_valid    (ID_EX_Valid),
    .ex_mem_read (ID_EX_MemRead),
    .ex_rd       (ID_EX_RD),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hazard      (hazard)
  );

  // A taken branch squashes ID anyway, so a coincident hazard must not freeze the front end.
  assign stall          = hazard & ~branch_taken_flush;
  assign pc_write_en    = ~stall;
  assign if_id_write_en = ~stall;
  assign cnt_at_max     = (stall_count == {CNT_W{1'b1}});

  // Pipeline register: bubbles clear valid and control but keep data/index/funct.
  always_ff @(posedge clk) begin
    if (reset) begin
      ID_EX_Valid    <= 1'b0;
      ID_EX_PC       <= '0;
      ID_EX_RS1_Data <= '0;
      ID_EX_RS2_Data <= '0;
      ID_EX_Imm      <= '0;
      ID_EX_RS1      <= '0;
      ID_EX_RS2      <= '0;
      ID_EX_RD       <= '0;
      ID_EX_Funct    <= '0;
      ex_ctrl        <= CTRL_BUBBLE;
    end else if (branch_taken_flush || stall) begin
      ID_EX_Valid <= 1'b0;
      ex_ctrl     <= CTRL_BUBBLE;
    end else begin
      ID_EX_Valid    <= id_valid;
      ID_EX_PC       <= id_pc;
      ID_EX_RS1_Data <= id_rs1_data;
      ID_EX_RS2_Data <= id_rs2_data;
      ID_EX_Imm      <= id_imm;
      ID_EX_RS1      <= id_rs1;
      ID_EX_RS2      <= id_rs2;
      ID_EX_RD       <= id_rd;
      ID_EX_Funct    <= id_funct;
      ex_ctrl        <= id_valid ? id_ctrl : CTRL_BUBBLE;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && !cnt_at_max) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign ID_EX_RegWrite = ex_ctrl.reg_write;
  assign ID_EX_MemRead  = ex_ctrl.mem_read;
  assign ID_EX_MemWrite = ex_ctrl.mem_write;
  assign ID_EX_MemToReg = ex_ctrl.mem_to_reg;
  assign ID_EX_ALUSrc   = ex_ctrl.alu_src;
  assign ID_EX_Branch   = ex_ctrl.branch;
  assign ID_EX_ALUOp    = ex_ctrl.alu_op;

endmodule
